// File: rtl/vga_sprite_pkg.sv
// Shared types, reset tables and palette for the VGA sprite scheduler.
// Sprites are 40x40 squares bounced around the 640x480 active area.
package vga_sprite_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       dir_x;
        logic       dir_y;
    } sprite_t;

    localparam logic [23:0] PAL_WHITE = 24'hFFFFFF;
    localparam logic [23:0] PAL_RED   = 24'hFF0000;
    localparam logic [23:0] PAL_GREEN = 24'h00FF00;
    localparam logic [23:0] PAL_BLUE  = 24'h0000FF;

    function automatic sprite_t init_sprite(input int i);
        sprite_t s;
        s.x     = 10'(40 + 140 * i);
        s.y     = 10'(40 + 90 * i);
        s.dir_x = i[0];
        s.dir_y = i[1];
        return s;
    endfunction

    function automatic logic [23:0] palette(input int i);
        logic [23:0] c;
        case (i)
            0:       c = PAL_WHITE;
            1:       c = PAL_RED;
            2:       c = PAL_GREEN;
            default: c = PAL_BLUE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_sprite_scheduler_axis_step.sv
// One-axis bounce step: advance pos by step toward dir, clamping at 0 / limit.
// Reaching an edge (including landing exactly on it) reverses the direction.
module sprite_axis_step (
    input  logic [9:0] pos,
    input  logic       dir,
    input  logic [2:0] step,
    input  logic [9:0] limit,
    output logic [9:0] next_pos,
    output logic       next_dir
);

    logic [10:0] sum;

    assign sum = {1'b0, pos} + {8'b0, step};

    always_comb begin
        next_pos = pos;
        next_dir = dir;
        if (dir) begin
            if (sum >= {1'b0, limit}) begin
                next_pos = limit;
                next_dir = 1'b0;
            end else begin
                next_pos = sum[9:0];
            end
        end else begin
            if ({1'b0, pos} <= {8'b0, step}) begin
                next_pos = '0;
                next_dir = 1'b1;
            end else begin
                next_pos = pos - {7'b0, step};
            end
        end
    end

endmodule

// File: rtl/vga_sprite_scheduler.sv
// Frame-synchronous sprite mover: steps up to four squares once per update
// at vertical blanking and resolves per-pixel hits into a priority colour.
module vga_sprite_scheduler
    import vga_sprite_pkg::*;
#(
    parameter int NUM_OBJ   = 4,
    parameter int OBJ_SIZE  = 40,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int FRAME_DIV = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [9:0]         pixel_X_pos,
    input  logic [9:0]         pixel_Y_pos,
    input  logic               pause,
    input  logic [1:0]         speed,
    output logic [NUM_OBJ-1:0] object_on,
    output logic [7:0]         VGA_red,
    output logic [7:0]         VGA_green,
    output logic [7:0]         VGA_blue,
    output logic               update_busy,
    output logic [7:0]         frame_count
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_OBJ - 1);
    localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);
    localparam logic [9:0] LIM_X    = 10'(H_ACTIVE - OBJ_SIZE);
    localparam logic [9:0] LIM_Y    = 10'(V_ACTIVE - OBJ_SIZE);

    state_t      state, state_nx;
    sprite_t     spr [NUM_OBJ];
    logic [1:0]  idx;
    logic [2:0]  step_r;
    logic [7:0]  divider;
    logic        vblank_pulse;
    logic        start;
    logic [9:0]  nx_x, nx_y;
    logic        nd_x, nd_y;
    logic [3:0]  hits;
    logic [23:0] rgb;

    assign vblank_pulse = enable && pixel_Y_pos == 10'(V_ACTIVE)
                          && pixel_X_pos == 10'd0;
    assign start        = vblank_pulse && divider == DIV_LAST && !pause;
    assign update_busy  = state != S_IDLE;

    sprite_axis_step u_step_x (
        .pos      (spr[idx].x),
        .dir      (spr[idx].dir_x),
        .step     (step_r),
        .limit    (LIM_X),
        .next_pos (nx_x),
        .next_dir (nd_x)
    );

    sprite_axis_step u_step_y (
        .pos      (spr[idx].y),
        .dir      (spr[idx].dir_y),
        .step     (step_r),
        .limit    (LIM_Y),
        .next_pos (nx_y),
        .next_dir (nd_y)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_STEP;
            S_STEP:  if (idx == LAST_IDX) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            step_r      <= '0;
            divider     <= '0;
            frame_count <= '0;
            for (int i = 0; i < NUM_OBJ; i++) spr[i] <= init_sprite(i);
        end else begin
            state <= state_nx;
            if (vblank_pulse)
                divider <= (divider == DIV_LAST) ? 8'd0 : divider + 8'd1;
            unique case (state)
                S_IDLE: if (start) begin
                    idx    <= '0;
                    step_r <= {1'b0, speed} + 3'd1;
                end
                S_STEP: begin
                    spr[idx].x     <= nx_x;
                    spr[idx].y     <= nx_y;
                    spr[idx].dir_x <= nd_x;
                    spr[idx].dir_y <= nd_y;
                    if (idx != LAST_IDX) idx <= idx + 2'd1;
                end
                S_DONE: frame_count <= frame_count + 8'd1;
                default: ;
            endcase
        end
    end

    // Unused slots stay dark so the colour mux can always scan four entries.
    for (genvar i = 0; i < 4; i++) begin : g_hit
        if (i < NUM_OBJ) begin : g_on
            assign hits[i] =
                {1'b0, pixel_X_pos} >= {1'b0, spr[i].x} &&
                {1'b0, pixel_X_pos} <  {1'b0, spr[i].x} + 11'(OBJ_SIZE) &&
                {1'b0, pixel_Y_pos} >= {1'b0, spr[i].y} &&
                {1'b0, pixel_Y_pos} <  {1'b0, spr[i].y} + 11'(OBJ_SIZE);
        end else begin : g_off
            assign hits[i] = 1'b0;
        end
    end

    always_comb begin
        rgb = 24'h000000;
        for (int i = 3; i >= 0; i--)
            if (hits[i]) rgb = palette(i);
    end

    assign object_on = hits[NUM_OBJ-1:0];
    assign VGA_red   = rgb[23:16];
    assign VGA_green = rgb[15:8];
    assign VGA_blue  = rgb[7:0];

endmodule

// File: tb/tb_vga_sprite_scheduler.sv
// Randomised frame-level bench for vga_sprite_scheduler against a simple
// bounce model; positions are observed through the pixel hit outputs.
module tb_vga_sprite_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [9:0] pixel_X_pos, pixel_Y_pos;
    logic       pause;
    logic [1:0] speed;
    logic [3:0] object_on, object_on3;
    logic [7:0] VGA_red, VGA_green, VGA_blue;
    logic [7:0] red3, green3, blue3;
    logic       update_busy, busy3;
    logic [7:0] frame_count, frame_count3;

    int n_checks = 0;
    int n_errors = 0;

    int mx[4], my[4], mdx[4], mdy[4];
    int mfc, mdiv, mfc3, mdiv3;

    always #10 clock = ~clock;

    vga_sprite_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .pixel_X_pos (pixel_X_pos),
        .pixel_Y_pos (pixel_Y_pos),
        .pause       (pause),
        .speed       (speed),
        .object_on   (object_on),
        .VGA_red     (VGA_red),
        .VGA_green   (VGA_green),
        .VGA_blue    (VGA_blue),
        .update_busy (update_busy),
        .frame_count (frame_count)
    );

    vga_sprite_scheduler #(.FRAME_DIV(3)) dut3 (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .pixel_X_pos (pixel_X_pos),
        .pixel_Y_pos (pixel_Y_pos),
        .pause       (pause),
        .speed       (speed),
        .object_on   (object_on3),
        .VGA_red     (red3),
        .VGA_green   (green3),
        .VGA_blue    (blue3),
        .update_busy (busy3),
        .frame_count (frame_count3)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mx[i]  = 40 + 140 * i;
            my[i]  = 40 + 90 * i;
            mdx[i] = i % 2;
            mdy[i] = i / 2;
        end
        mfc = 0; mdiv = 0; mfc3 = 0; mdiv3 = 0;
    endtask

    function automatic void bounce(inout int p, inout int d,
                                   input int s, input int lim);
        if (d == 1) begin
            p = p + s;
            if (p >= lim) begin p = lim; d = 0; end
        end else begin
            p = p - s;
            if (p <= 0) begin p = 0; d = 1; end
        end
    endfunction

    function automatic logic [3:0] model_hits(input int px, input int py);
        logic [3:0] h = '0;
        for (int i = 0; i < 4; i++)
            h[i] = px >= mx[i] && px < mx[i] + 40 &&
                   py >= my[i] && py < my[i] + 40;
        return h;
    endfunction

    function automatic int model_rgb(input logic [3:0] h);
        if (h[0]) return 32'hFFFFFF;
        if (h[1]) return 32'hFF0000;
        if (h[2]) return 32'h00FF00;
        if (h[3]) return 32'h0000FF;
        return 0;
    endfunction

    task automatic probe_at(input int px, input int py);
        int x = px & 1023;
        int y = py & 1023;
        logic [3:0] h;
        enable      = 1'b0;
        pixel_X_pos = 10'(x);
        pixel_Y_pos = 10'(y);
        #1;
        h = model_hits(x, y);
        check("object_on", int'(object_on), int'(h));
        check("rgb", int'({VGA_red, VGA_green, VGA_blue}), model_rgb(h));
    endtask

    task automatic probe_all();
        for (int i = 0; i < 4; i++) begin
            probe_at(mx[i],      my[i]);
            probe_at(mx[i] - 1,  my[i]);
            probe_at(mx[i],      my[i] - 1);
            probe_at(mx[i] + 39, my[i] + 39);
            probe_at(mx[i] + 40, my[i] + 39);
            probe_at(mx[i] + 39, my[i] + 40);
        end
    endtask

    task automatic send_pulse();
        @(negedge clock);
        enable      = 1'b1;
        pixel_X_pos = 10'd0;
        pixel_Y_pos = 10'd480;
        @(posedge clock);
        #1;
        enable      = 1'b0;
        pixel_Y_pos = 10'd100;
    endtask

    task automatic do_frame(input bit p, input int spd);
        bit upd;
        int busy_cnt = 0;
        pause = p;
        speed = 2'(spd);
        send_pulse();
        for (int c = 0; c < 8; c++) begin
            busy_cnt += int'(update_busy);
            @(posedge clock);
            #1;
        end
        upd = 0;
        if (mdiv == 0) upd = !p;
        else mdiv++;
        if (upd) begin
            for (int i = 0; i < 4; i++) begin
                bounce(mx[i], mdx[i], spd + 1, 600);
                bounce(my[i], mdy[i], spd + 1, 440);
            end
            mfc = (mfc + 1) % 256;
        end
        if (mdiv3 == 2) begin
            mdiv3 = 0;
            if (!p) mfc3 = (mfc3 + 1) % 256;
        end else begin
            mdiv3++;
        end
        check("busy_cycles", busy_cnt, upd ? 5 : 0);
        check("frame_count", int'(frame_count), mfc);
        check("frame_count_div3", int'(frame_count3), mfc3);
        probe_all();
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        pixel_X_pos = '0;
        pixel_Y_pos = '0;
        pause       = 1'b0;
        speed       = 2'd0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", int'(update_busy), 0);
        check("reset_frame_count", int'(frame_count), 0);
        @(negedge clock);
        reset = 1'b0;
        probe_all();
        probe_at(330, 230);
        check("overlap_green", int'({VGA_red, VGA_green, VGA_blue}), 32'h00FF00);
        probe_at(0, 470);
        check("corner_black", int'({VGA_red, VGA_green, VGA_blue}), 0);
        probe_at(50, 50);
        check("div3_white", int'(object_on3), 1);
        check("div3_rgb", int'({red3, green3, blue3}), 32'hFFFFFF);

        do_frame(1'b0, 0);
        probe_at(39, 39);
        check("sq0_moved", int'(object_on), 4'b0001);
        probe_at(181, 129);
        check("sq1_moved", int'(object_on), 4'b0010);
        check("first_frame_count", int'(frame_count), 1);

        for (int f = 0; f < 3; f++) do_frame(1'b1, 2);

        // Reset while the sweep is on square 2.
        pause = 1'b0;
        send_pulse();
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("mid_sweep_busy", int'(update_busy), 1);
        reset = 1'b1;
        #1;
        check("mid_reset_busy", int'(update_busy), 0);
        check("mid_reset_count", int'(frame_count), 0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        probe_all();

        for (int f = 0; f < 6; f++) do_frame(1'b0, int'($urandom_range(0, 3)));
        check("div3_after_6", int'(frame_count3), 2);
        check("div1_after_6", int'(frame_count), 6);

        for (int f = 0; f < 400; f++)
            do_frame(($urandom % 8) == 0, int'($urandom_range(0, 3)));

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
